// File: rtl/stuck_bus_monitor.sv
// Classifies each accepted sample as all-zero / all-one / mixed and tracks runs of
// identical saturated samples; a run reaching THRESH pulses alarm and sets a sticky flag.
module stuck_bus_monitor #(
  parameter int WIDTH  = 5,
  parameter int THRESH = 4,
  parameter int CNT_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x,
  input  logic             x_valid,
  input  logic             clr,
  output logic             zero,
  output logic             one,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] run_cnt,
  output logic             alarm,
  output logic             stuck_zero,
  output logic             stuck_one
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ZRUN = 2'b01,
    ORUN = 2'b10
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             zero_q, zero_d;
  logic             one_q, one_d;
  logic             alarm_q, alarm_d;
  logic             sz_q, sz_d;
  logic             so_q, so_d;

  logic samp_z, samp_o;
  logic new_run;
  logic thresh_evt;

  assign samp_z = ~|x;
  assign samp_o = &x;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    one_d   = one_q;
    new_run = 1'b0;
    if (x_valid) begin
      if (samp_z) begin
        zero_d = 1'b1;
        one_d  = 1'b0;
        if (state_q == ZRUN) begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end else begin
          state_d = ZRUN;
          cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
          new_run = 1'b1;
        end
      end else if (samp_o) begin
        zero_d = 1'b0;
        one_d  = 1'b1;
        if (state_q == ORUN) begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end else begin
          state_d = ORUN;
          cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
          new_run = 1'b1;
        end
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
        zero_d  = 1'b0;
        one_d   = 1'b0;
      end
    end
  end

  // A freshly started run counts as a transition into THRESH even if the
  // previous opposite-polarity run happened to sit at the same count.
  always_comb begin
    thresh_evt = x_valid && (cnt_d == THR) && (new_run || (cnt_q != THR));
    alarm_d    = thresh_evt;
    sz_d       = clr ? 1'b0 : sz_q;
    so_d       = clr ? 1'b0 : so_q;
    if (thresh_evt && (state_d == ZRUN)) sz_d = 1'b1;
    if (thresh_evt && (state_d == ORUN)) so_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      one_q   <= 1'b0;
      alarm_q <= 1'b0;
      sz_q    <= 1'b0;
      so_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      one_q   <= one_d;
      alarm_q <= alarm_d;
      sz_q    <= sz_d;
      so_q    <= so_d;
    end
  end

  assign zero       = zero_q;
  assign one        = one_q;
  assign state      = state_q;
  assign run_cnt    = cnt_q;
  assign alarm      = alarm_q;
  assign stuck_zero = sz_q;
  assign stuck_one  = so_q;

endmodule

// File: tb/tb_stuck_bus_monitor.sv
// Directed bench for stuck_bus_monitor with hand-computed expectations (THRESH=4, CNT_W=4).
module tb_stuck_bus_monitor;

  logic       clk;
  logic       rst;
  logic [4:0] x;
  logic       x_valid;
  logic       clr;
  logic       zero;
  logic       one;
  logic [1:0] state;
  logic [3:0] run_cnt;
  logic       alarm;
  logic       stuck_zero;
  logic       stuck_one;

  int n_cmp;
  int n_err;
  int n_alarm;

  stuck_bus_monitor #(.WIDTH(5), .THRESH(4), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .x          (x),
    .x_valid    (x_valid),
    .clr        (clr),
    .zero       (zero),
    .one        (one),
    .state      (state),
    .run_cnt    (run_cnt),
    .alarm      (alarm),
    .stuck_zero (stuck_zero),
    .stuck_one  (stuck_one)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one clock edge with given inputs; returns #1 after the edge with inputs idled
  task automatic send(input logic [4:0] v, input logic vld, input logic c);
    @(negedge clk);
    x       = v;
    x_valid = vld;
    clr     = c;
    @(posedge clk);
    #1;
    x_valid = 1'b0;
    clr     = 1'b0;
  endtask

  task automatic check_all(input string tag, input logic [1:0] st, input logic [3:0] cnt,
                           input logic z, input logic o, input logic al,
                           input logic sz, input logic so);
    check({tag, "_state"}, 32'(state), 32'(st));
    check({tag, "_cnt"},   32'(run_cnt), 32'(cnt));
    check({tag, "_zero"},  32'(zero), 32'(z));
    check({tag, "_one"},   32'(one), 32'(o));
    check({tag, "_alarm"}, 32'(alarm), 32'(al));
    check({tag, "_sz"},    32'(stuck_zero), 32'(sz));
    check({tag, "_so"},    32'(stuck_one), 32'(so));
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    rst     = 1'b1;
    x       = '0;
    x_valid = 1'b0;
    clr     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all("reset", 2'b00, 4'd0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // run of zeros interrupted by asynchronous reset between edges
    for (int i = 1; i <= 3; i++) begin
      send(5'b00000, 1'b1, 1'b0);
      check_all("pre_rst", 2'b01, 4'(i), 1, 0, 0, 0, 0);
    end
    #1;
    rst = 1'b1;
    #1;
    check_all("async_rst", 2'b00, 4'd0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // zero run reaching THRESH
    for (int i = 1; i <= 4; i++) begin
      send(5'b00000, 1'b1, 1'b0);
      check_all("zrun", 2'b01, 4'(i), 1, 0, (i == 4), (i == 4), 0);
    end
    send(5'b00000, 1'b0, 1'b0);
    check_all("zrun_hold", 2'b01, 4'd4, 1, 0, 0, 1, 0);

    // one run with a long gap, then a break
    for (int i = 1; i <= 3; i++) begin
      send(5'b11111, 1'b1, 1'b0);
      check_all("orun", 2'b10, 4'(i), 0, 1, 0, 1, 0);
    end
    for (int i = 0; i < 5; i++) begin
      send(5'b11111, 1'b0, 1'b0);
      check_all("gap", 2'b10, 4'd3, 0, 1, 0, 1, 0);
    end
    send(5'b11111, 1'b1, 1'b0);
    check_all("gap_thr", 2'b10, 4'd4, 0, 1, 1, 1, 1);
    send(5'b10110, 1'b1, 1'b0);
    check_all("break", 2'b00, 4'd0, 0, 0, 0, 1, 1);

    // polarity switch restarts the run
    for (int i = 1; i <= 3; i++) begin
      send(5'b00000, 1'b1, 1'b0);
      check_all("pol_z", 2'b01, 4'(i), 1, 0, 0, 1, 1);
    end
    send(5'b11111, 1'b1, 1'b0);
    check_all("pol_sw", 2'b10, 4'd1, 0, 1, 0, 1, 1);

    // saturation at 15 with a single alarm, then clear
    send(5'b01001, 1'b1, 1'b0);
    check_all("sat_brk", 2'b00, 4'd0, 0, 0, 0, 1, 1);
    n_alarm = 0;
    for (int i = 1; i <= 20; i++) begin
      send(5'b11111, 1'b1, 1'b0);
      if (alarm) n_alarm++;
      check("sat_cnt", 32'(run_cnt), (i > 15) ? 32'd15 : 32'(i));
      check("sat_alarm", 32'(alarm), (i == 4) ? 32'd1 : 32'd0);
    end
    check("sat_alarm_total", 32'(n_alarm), 32'd1);
    send(5'b11111, 1'b0, 1'b1);
    check_all("sat_clr", 2'b10, 4'd15, 0, 1, 0, 0, 0);

    // clear colliding with a zero-run threshold event
    send(5'b10110, 1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) send(5'b11111, 1'b1, 1'b0);
    check_all("coll_prep", 2'b10, 4'd4, 0, 1, 1, 0, 1);
    send(5'b10110, 1'b1, 1'b0);
    for (int i = 1; i <= 3; i++) send(5'b00000, 1'b1, 1'b0);
    check_all("coll_pre", 2'b01, 4'd3, 1, 0, 0, 0, 1);
    send(5'b00000, 1'b1, 1'b1);
    check_all("coll", 2'b01, 4'd4, 1, 0, 1, 1, 0);
    send(5'b00000, 1'b1, 1'b0);
    check_all("coll_after", 2'b01, 4'd5, 1, 0, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
